// File: rtl/display_write.sv
// Signed 14-bit result to 4-digit multiplexed 7-segment display via serial double-dabble.
// Latency: load at cycle N, display registers updated at the end of cycle N+16; seg follows one cycle later.
// Backpressure: busy is high while converting; a load arriving while busy is dropped.
module display_write #(
    parameter logic [15:0] SCAN_DIV = 16'd1000
) (
    input  logic        clk_hf,
    input  logic        rst,
    input  logic        load,
    input  logic        neg,
    input  logic [13:0] value,
    output logic        busy,
    output logic [3:0]  an,
    output logic [6:0]  seg
);

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t      state, state_nxt;
    logic [15:0] bcd, bcd_nxt, bcd_adj;
    logic [13:0] bin, bin_nxt;
    logic [13:0] op_val;
    logic        op_neg;
    logic [3:0]  cnt, cnt_nxt;
    logic        cap, commit, ovf;

    logic [15:0] disp_bcd;
    logic        disp_neg, disp_ovf;

    logic [15:0] scan_cnt;
    logic [1:0]  idx, idx_nxt, msd;
    logic        wrap, show_minus;
    logic [3:0]  nib;
    logic [6:0]  seg_nxt;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'h3F;
            4'd1:    seg_of = 7'h06;
            4'd2:    seg_of = 7'h5B;
            4'd3:    seg_of = 7'h4F;
            4'd4:    seg_of = 7'h66;
            4'd5:    seg_of = 7'h6D;
            4'd6:    seg_of = 7'h7D;
            4'd7:    seg_of = 7'h07;
            4'd8:    seg_of = 7'h7F;
            4'd9:    seg_of = 7'h6F;
            default: seg_of = 7'h00;
        endcase
    endfunction

    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < 4; k++) begin
            if (bcd[k*4 +: 4] >= 4'd5)
                bcd_adj[k*4 +: 4] = bcd[k*4 +: 4] + 4'd3;
        end
    end

    // Counter reaching zero spends one extra CONV cycle before COMMIT, giving the 16-cycle busy window.
    always_comb begin
        state_nxt = state;
        bcd_nxt   = bcd;
        bin_nxt   = bin;
        cnt_nxt   = cnt;
        cap       = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    cap       = 1'b1;
                    bcd_nxt   = '0;
                    bin_nxt   = value;
                    cnt_nxt   = 4'd14;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (cnt == 4'd0) begin
                    state_nxt = COMMIT;
                end else begin
                    bcd_nxt = {bcd_adj[14:0], bin[13]};
                    bin_nxt = {bin[12:0], 1'b0};
                    cnt_nxt = cnt - 4'd1;
                end
            end
            COMMIT: begin
                commit    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign ovf  = (op_val > 14'd9999) || (op_neg && (op_val > 14'd999));

    always_ff @(posedge clk_hf or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            bcd      <= '0;
            bin      <= '0;
            cnt      <= '0;
            op_val   <= '0;
            op_neg   <= 1'b0;
            disp_bcd <= '0;
            disp_neg <= 1'b0;
            disp_ovf <= 1'b0;
        end else begin
            state <= state_nxt;
            bcd   <= bcd_nxt;
            bin   <= bin_nxt;
            cnt   <= cnt_nxt;
            if (cap) begin
                op_val <= value;
                op_neg <= neg;
            end
            if (commit) begin
                disp_bcd <= bcd;
                disp_neg <= op_neg;
                disp_ovf <= ovf;
            end
        end
    end

    assign wrap    = (scan_cnt == SCAN_DIV - 16'd1);
    assign idx_nxt = wrap ? idx + 2'd1 : idx;

    always_comb begin
        if (disp_bcd[15:12] != 4'd0)      msd = 2'd3;
        else if (disp_bcd[11:8] != 4'd0)  msd = 2'd2;
        else if (disp_bcd[7:4] != 4'd0)   msd = 2'd1;
        else                              msd = 2'd0;
    end

    assign show_minus = disp_neg && !disp_ovf && (disp_bcd != 16'd0);
    assign nib        = disp_bcd[{idx_nxt, 2'b00} +: 4];

    // Segment code is computed for the index being entered so an and seg switch on the same edge.
    always_comb begin
        seg_nxt = 7'h00;
        if (disp_ovf) begin
            if (idx_nxt == 2'd0)
                seg_nxt = 7'h79;
        end else if (idx_nxt <= msd) begin
            seg_nxt = seg_of(nib);
        end else if (show_minus && ({1'b0, idx_nxt} == {1'b0, msd} + 3'd1)) begin
            seg_nxt = 7'h40;
        end
    end

    always_ff @(posedge clk_hf or negedge rst) begin
        if (!rst) begin
            scan_cnt <= '0;
            idx      <= '0;
            an       <= 4'b0001;
            seg      <= 7'h3F;
        end else begin
            scan_cnt <= wrap ? 16'd0 : scan_cnt + 16'd1;
            idx      <= idx_nxt;
            an       <= 4'b0001 << idx_nxt;
            seg      <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_display_write.sv
// Directed bench for display_write: scan sequence, conversion latency, blanking/sign/overflow, load-while-busy, mid-conversion reset.
module tb_display_write;

    localparam logic [15:0] SD = 16'd4;
    localparam int SDI = 4;

    logic        clk_hf = 1'b0;
    logic        rst;
    logic        load;
    logic        neg;
    logic [13:0] value;
    logic        busy;
    logic [3:0]  an;
    logic [6:0]  seg;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [6:0]  digs [4];
    logic [3:0]  seen;
    int          bc;

    display_write #(.SCAN_DIV(SD)) dut (
        .clk_hf (clk_hf),
        .rst    (rst),
        .load   (load),
        .neg    (neg),
        .value  (value),
        .busy   (busy),
        .an     (an),
        .seg    (seg)
    );

    always #5 clk_hf = ~clk_hf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Counts busy cycles after a load; bounded so a stuck FSM cannot hang the run.
    task automatic count_busy(output int cnt);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            cnt++;
            @(negedge clk_hf);
        end
    endtask

    task automatic scan_digits(input string tag);
        seen = 4'h0;
        for (int c = 0; c < 4 * SDI; c++) begin
            @(negedge clk_hf);
            case (an)
                4'b0001: begin digs[0] = seg; seen[0] = 1'b1; end
                4'b0010: begin digs[1] = seg; seen[1] = 1'b1; end
                4'b0100: begin digs[2] = seg; seen[2] = 1'b1; end
                4'b1000: begin digs[3] = seg; seen[3] = 1'b1; end
                default: seen = seen;
            endcase
        end
        chk({tag, "_scan"}, 32'(seen), 32'hF);
    endtask

    task automatic chk_digits(input string tag, input logic [6:0] e3, input logic [6:0] e2,
                              input logic [6:0] e1, input logic [6:0] e0);
        scan_digits(tag);
        chk({tag, "_d3"}, 32'(digs[3]), 32'(e3));
        chk({tag, "_d2"}, 32'(digs[2]), 32'(e2));
        chk({tag, "_d1"}, 32'(digs[1]), 32'(e1));
        chk({tag, "_d0"}, 32'(digs[0]), 32'(e0));
    endtask

    task automatic conv(input string tag, input logic [13:0] v, input logic n,
                        input logic [6:0] e3, input logic [6:0] e2,
                        input logic [6:0] e1, input logic [6:0] e0);
        value = v;
        neg   = n;
        load  = 1'b1;
        @(negedge clk_hf);
        load  = 1'b0;
        count_busy(bc);
        chk({tag, "_busy"}, 32'(bc), 32'd16);
        chk_digits(tag, e3, e2, e1, e0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst   = 1'b0;
        load  = 1'b0;
        neg   = 1'b0;
        value = '0;
        repeat (3) @(negedge clk_hf);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_an", 32'(an), 32'h1);
        chk("rst_seg", 32'(seg), 32'h3F);

        // Scan order after reset: digit 0 shows 0, the rest blank.
        rst = 1'b1;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("scan_an%0d", d), 32'(an), 32'(4'b0001 << d));
            chk($sformatf("scan_seg%0d", d), 32'(seg), (d == 0) ? 32'h3F : 32'h00);
            repeat (SDI) @(negedge clk_hf);
        end

        conv("v1234",  14'd1234,  1'b0, 7'h06, 7'h5B, 7'h4F, 7'h66);
        conv("vm42",   14'd42,    1'b1, 7'h00, 7'h40, 7'h66, 7'h5B);
        conv("vm0",    14'd0,     1'b1, 7'h00, 7'h00, 7'h00, 7'h3F);
        conv("v10000", 14'd10000, 1'b0, 7'h00, 7'h00, 7'h00, 7'h79);
        conv("vm1000", 14'd1000,  1'b1, 7'h00, 7'h00, 7'h00, 7'h79);
        conv("vm999",  14'd999,   1'b1, 7'h40, 7'h6F, 7'h6F, 7'h6F);
        conv("v5",     14'd5,     1'b0, 7'h00, 7'h00, 7'h00, 7'h6D);
        conv("v16383", 14'd16383, 1'b0, 7'h00, 7'h00, 7'h00, 7'h79);
        conv("v8080",  14'd8080,  1'b0, 7'h7F, 7'h3F, 7'h7F, 7'h3F);
        conv("vm7",    14'd7,     1'b1, 7'h00, 7'h00, 7'h40, 7'h07);

        // Second load during conversion must be dropped.
        value = 14'd9999;
        neg   = 1'b0;
        load  = 1'b1;
        @(negedge clk_hf);
        load = 1'b0;
        bc   = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            bc++;
            if (i == 4) begin
                value = 14'd1;
                load  = 1'b1;
            end else begin
                load  = 1'b0;
            end
            @(negedge clk_hf);
        end
        load = 1'b0;
        chk("ign_busy", 32'(bc), 32'd16);
        chk_digits("ign", 7'h6F, 7'h6F, 7'h6F, 7'h6F);

        // Reset in the middle of a conversion.
        value = 14'd5678;
        neg   = 1'b0;
        load  = 1'b1;
        @(negedge clk_hf);
        load = 1'b0;
        repeat (6) @(negedge clk_hf);
        chk("abort_busy_pre", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_an", 32'(an), 32'h1);
        chk("abort_seg", 32'(seg), 32'h3F);
        @(negedge clk_hf);
        rst = 1'b1;
        chk_digits("abort", 7'h00, 7'h00, 7'h00, 7'h3F);
        conv("after", 14'd7, 1'b0, 7'h00, 7'h00, 7'h00, 7'h07);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
